// File: rtl/wiscsc15_pkg.sv
// Shared definitions for the WISC-SC15 front end: instruction width, opcodes, fetch FSM states.
package wiscsc15_pkg;

    localparam int unsigned ILEN = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALTED
    } fetch_state_e;

    function automatic logic is_hlt(input logic [ILEN-1:0] word);
        return word[ILEN-1 -: 4] == OP_HLT;
    endfunction

endpackage

// File: rtl/wiscsc15_fetch_fifo.sv
// In-order prefetch buffer: DEPTH entries of W bits with push/pop/flush and occupancy count.
module wiscsc15_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          full, do_push, do_pop;

    assign empty   = count_q == '0;
    assign full    = count_q == CW'(DEPTH);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty && !flush;
    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 fetch/issue stage: credit-limited IM prefetch into an in-order buffer,
// redirect handling with stale-response discard, and stop on HLT.
module wiscsc15_fetch
    import wiscsc15_pkg::*;
#(
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            im_req,
    output logic [AW-1:0]   im_addr,
    input  logic            im_gnt,
    input  logic            im_rvalid,
    input  logic [15:0]     im_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [15:0]     instr,
    output logic [3:0]      opcode,
    output logic [AW-1:0]   instr_pc,
    input  logic            redirect,
    input  logic [AW-1:0]   redirect_pc,
    output logic            halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = ILEN + AW;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] stale_q, stale_d;

    logic [CW-1:0] count;
    logic [CW:0]   credit;
    logic [EW-1:0] head;
    logic          fifo_empty;
    logic          run, issue, pop, hlt_pop, resp_write, flush;

    assign run    = state_q == FS_RUN;
    // Buffered plus in-flight words (stale ones included) never exceed the buffer size.
    assign credit = {1'b0, count} + {1'b0, outstanding_q};

    assign im_req      = run && !redirect && (credit < (CW+1)'(DEPTH));
    assign im_addr     = fetch_pc_q;
    assign issue       = im_req && im_gnt;
    assign instr_valid = run && !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? head[EW-1 -: ILEN] : '0;
    assign instr_pc    = instr_valid ? head[AW-1:0] : '0;
    assign opcode      = instr[ILEN-1 -: 4];
    assign halted      = state_q == FS_HALTED;
    assign hlt_pop     = pop && !redirect && is_hlt(instr);
    assign resp_write  = run && !redirect && im_rvalid && (stale_q == '0);
    assign flush       = (run && redirect) || hlt_pop;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;

        if (im_rvalid && outstanding_q != '0) outstanding_d = outstanding_q - CW'(1);
        if (issue)                            outstanding_d = outstanding_d + CW'(1);
        if (im_rvalid && stale_q != '0)       stale_d       = stale_q - CW'(1);
        if (resp_write)                       resp_pc_d     = resp_pc_q + AW'(1);
        if (issue)                            fetch_pc_d    = fetch_pc_q + AW'(1);

        unique case (state_q)
            FS_IDLE: state_d = FS_RUN;
            FS_RUN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    resp_pc_d  = redirect_pc;
                    // No issue in a redirect cycle, so this is outstanding minus any response.
                    stale_d    = outstanding_d;
                end else if (hlt_pop) begin
                    state_d = FS_HALTED;
                end
            end
            FS_HALTED: state_d = FS_HALTED;
            default:   state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FS_IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    wiscsc15_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (resp_write),
        .wdata ({im_rdata, resp_pc_q}),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .empty (fifo_empty),
        .count (count)
    );

endmodule
